// File: rtl/pipelined_add_sub.sv
// Carry-pipelined adder/subtractor: CHUNK-bit ripple slices, one slice per registered stage,
// with a single global advance enable driven by the output handshake.
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_param
        $fatal(1, "pipelined_add_sub: WIDTH must be a positive multiple of CHUNK");
    end

    // Per-stage registers; each stage carries the full operand/partial-sum words and the
    // stage only rewrites its own slice of the partial sum.
    logic [WIDTH-1:0] a_reg [STAGES];
    logic [WIDTH-1:0] b_reg [STAGES];
    logic [WIDTH-1:0] s_reg [STAGES];
    logic             c_reg [STAGES];
    logic             v_reg [STAGES];
    logic             ovf_reg;
    logic             zero_reg;
    logic             neg_reg;

    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic [WIDTH-1:0] s_next [STAGES];
    logic             c_next [STAGES];
    logic [CHUNK:0]   slice_sum [STAGES];
    logic             msb_carry_in;
    logic             ovf_next;
    logic             adv;

    assign adv       = out_ready || !v_reg[LAST];
    assign in_ready  = adv;
    assign out_valid = v_reg[LAST];
    assign sum       = s_reg[LAST];
    assign cout      = c_reg[LAST];
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;

    always_comb begin
        // Subtraction is A + ~B + ~cin, so borrow-in maps onto an inverted carry-in.
        a_src[0] = inp1;
        b_src[0] = inp2 ^ {WIDTH{sub}};
        s_src[0] = '0;
        c_src[0] = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_reg[k-1];
            b_src[k] = b_reg[k-1];
            s_src[k] = s_reg[k-1];
            c_src[k] = c_reg[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                         + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, c_src[k]};
            s_next[k]                    = s_src[k];
            s_next[k][k*CHUNK +: CHUNK]  = slice_sum[k][CHUNK-1:0];
            c_next[k]                    = slice_sum[k][CHUNK];
        end
        // Carry into the MSB recovered from the MSB's own sum bit and operand bits.
        msb_carry_in = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ s_next[LAST][WIDTH-1];
        ovf_next     = msb_carry_in ^ c_next[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
                c_reg[k] <= 1'b0;
                v_reg[k] <= 1'b0;
            end
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else if (adv) begin
            v_reg[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_reg[k] <= v_reg[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k] <= a_src[k];
                b_reg[k] <= b_src[k];
                s_reg[k] <= s_next[k];
                c_reg[k] <= c_next[k];
            end
            ovf_reg  <= ovf_next;
            zero_reg <= ~|s_next[LAST];
            neg_reg  <= s_next[LAST][WIDTH-1];
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed boundary cases, streams with stalls, reset
// mid-flight and a randomized phase, all checked against an arithmetic reference model.
module tb_pipelined_add_sub;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] inp1;
    logic [W-1:0] inp2;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    pipelined_add_sub #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t        m;
        logic [W:0]  r;
        int          sa;
        int          sb;
        int          sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
            m.cout = ~r[W];
            sr     = sa - sb - int'(c);
        end else begin
            r      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            m.cout = r[W];
            sr     = sa + sb + int'(c);
        end
        m.sum  = r[W-1:0];
        m.ovf  = (sr > 32767) || (sr < -32768);
        m.zero = (r[W-1:0] == '0);
        m.neg  = r[W-1];
        m.due  = 0;
        return m;
    endfunction

    // One clock cycle: drive, check outputs against the model, record any accept.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic ordy, output logic acc);
        exp_t e;
        logic exp_v;
        in_valid  = iv;
        inp1      = a;
        inp2      = b;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        check("in_ready", {31'b0, in_ready}, {31'b0, (ordy || !exp_v)});
        if (exp_v && out_valid) begin
            check("sum",  {16'b0, sum},  {16'b0, exp_q[0].sum});
            check("cout", {31'b0, cout}, {31'b0, exp_q[0].cout});
            check("ovf",  {31'b0, ovf},  {31'b0, exp_q[0].ovf});
            check("zero", {31'b0, zero}, {31'b0, exp_q[0].zero});
            check("neg",  {31'b0, neg},  {31'b0, exp_q[0].neg});
            if (ordy) begin
                $display("txn out cycle=%0d sum=%h cout=%b ovf=%b zero=%b neg=%b",
                         cyc, sum, cout, ovf, zero, neg);
                void'(exp_q.pop_front());
            end else begin
                // The whole pipeline freezes, so every in-flight result slips by one cycle.
                foreach (exp_q[i]) exp_q[i].due++;
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e     = model(a, b, c, s);
            e.due = cyc + LAT;
            exp_q.push_back(e);
            $display("txn in  cycle=%0d a=%h b=%h cin=%b sub=%b", cyc, a, b, c, s);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        check("drain_timeout", {31'b0, (exp_q.size() > 0)}, 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'h7FFF;
            3:       v = 16'h8000;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Feeds A=i, B=0x1000*i for 8 ops; out_ready dropped for stream cycles lo..hi.
    task automatic stream(input int lo, input int hi);
        logic acc;
        int   i;
        int   j;
        i = 0;
        j = 0;
        while ((i < 8 || exp_q.size() > 0) && j < 100) begin
            step(i < 8, W'(i), W'(32'h1000 * i), 1'b0, 1'b0, !(j >= lo && j <= hi), acc);
            if (acc) i++;
            j++;
        end
        check("stream_timeout", {31'b0, (j >= 100)}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inp1      = '0;
        inp2      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset/idle state.
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum",  {16'b0, sum}, 32'd0);
        check("rst_flags", {28'b0, cout, ovf, zero, neg}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);

        // Directed boundary cases, issued back to back.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, acc);
        step(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, acc);
        drain();

        stream(-1, -1);
        stream(6, 9);

        // Reset mid-flight discards everything in the pipeline.
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_sum", {16'b0, sum}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b1, acc);
        drain();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
